// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes, frame builder.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // Frame shifted out LSB first: data, odd parity, stop.
    function automatic logic [9:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line input: 2-FF synchronizer, previous-sample register, fall detect.
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle bus level is high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= i_line;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign o_sync = sync_q;
    assign o_fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain line enables).
// Define PS2_TX_RETRY_EN to retransmit up to 2 times before flagging o_err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC  = 1200,
    parameter int START_TO_CYC = 150000,
    parameter int PKT_TO_CYC   = 20000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);

    localparam int MAX_A = (INHIBIT_CYC > START_TO_CYC) ? INHIBIT_CYC : START_TO_CYC;
    localparam int MAX_P = (MAX_A > PKT_TO_CYC) ? MAX_A : PKT_TO_CYC;
    localparam int TW    = $clog2(MAX_P);

    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TO_CYC - 1);
    localparam logic [TW-1:0] PKT_LAST   = TW'(PKT_TO_CYC - 1);

    logic clk_sync;
    logic clk_fall;
    logic data_sync;
    logic data_fall_unused;

    ps2_line_sync u_clk_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_line (i_ps2_clk),
        .o_sync (clk_sync),
        .o_fall (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_line (i_ps2_data),
        .o_sync (data_sync),
        .o_fall (data_fall_unused)
    );

    ps2_state_e    state_q, state_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          data_oe_q, data_oe_d;
    logic          clk_oe_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          fail;
`ifdef PS2_TX_RETRY_EN
    logic [7:0]    byte_q, byte_d;
    logic [1:0]    retry_q, retry_d;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        data_oe_d = data_oe_q;
        timer_d   = (&timer_q) ? timer_q : timer_q + 1'b1;
        fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        byte_d    = byte_q;
        retry_d   = retry_q;
`endif
        unique case (state_q)
            IDLE: begin
                timer_d   = '0;
                data_oe_d = 1'b0;
                if (i_valid && ready_q) begin
                    shreg_d  = ps2_frame(i_data);
                    bitcnt_d = '0;
                    state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    byte_d   = i_data;
                    retry_d  = '0;
`endif
                end
            end
            INHIBIT: begin
                if (timer_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    timer_d   = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (clk_fall) begin
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b1, shreg_q[9:1]};
                    bitcnt_d  = 4'd1;
                    timer_d   = '0;
                    state_d   = XFER;
                end else if (timer_q == START_LAST) begin
                    fail = 1'b1;
                end
            end
            XFER: begin
                if (timer_q == PKT_LAST) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b1, shreg_q[9:1]};
                    bitcnt_d  = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (timer_q == PKT_LAST) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    if (data_sync) begin
                        fail = 1'b1;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (timer_q == PKT_LAST) begin
                    fail = 1'b1;
                end else if (clk_sync && data_sync) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            ERR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fail) begin
            data_oe_d = 1'b0;
            timer_d   = '0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d  = retry_q + 2'd1;
                shreg_d  = ps2_frame(byte_q);
                bitcnt_d = '0;
                state_d  = INHIBIT;
            end else begin
                state_d  = ERR;
            end
`else
            state_d = ERR;
`endif
        end
    end

    // Status and line enables are registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            timer_q   <= '0;
            data_oe_q <= 1'b0;
            clk_oe_q  <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            byte_q    <= '0;
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            timer_q   <= timer_d;
            data_oe_q <= data_oe_d;
            clk_oe_q  <= (state_d == INHIBIT);
            ready_q   <= (state_d == IDLE);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            err_q     <= (state_d == ERR);
`ifdef PS2_TX_RETRY_EN
            byte_q    <= byte_d;
            retry_q   <= retry_d;
`endif
        end
    end

    assign o_ready       = ready_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign o_ps2_clk_oe  = clk_oe_q;
    assign o_ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard model on open-drain lines plus scoreboard.
module tb_ps2_host_tx;

    localparam int INH = 1200;
    localparam int STO = 3000;
    localparam int PTO = 2500;
    localparam int H   = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, busy, done, err;
    logic       clk_oe, data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = ~(clk_oe | dev_clk_low);
    assign ps2_data = ~(data_oe | dev_data_low);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_tx #(
        .INHIBIT_CYC  (INH),
        .START_TO_CYC (STO),
        .PKT_TO_CYC   (PTO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (valid),
        .i_data        (data),
        .o_ready       (ready),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .i_ps2_clk     (ps2_clk),
        .i_ps2_data    (ps2_data),
        .o_ps2_clk_oe  (clk_oe),
        .o_ps2_data_oe (data_oe)
    );

    typedef enum int {M_ACK, M_NOACK, M_SILENT} mode_e;

    typedef struct {
        bit         is_done;
        bit         chk_byte;
        bit         silent;
        logic [7:0] b;
        int         phases;
        int         base;
    } exp_t;

    exp_t  q[$];
    mode_e mode = M_ACK;
    int    abort_at = 0;
    int    total = 0;
    int    bad = 0;
    int    pulses = 0;
    int    excl_bad = 0;
    int    inhib_cnt = 0;
    int    last_inh_len = 0;
    int    aborts = 0;
    int    rel_cyc = 0;
    bit    req_ok = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic  rx_par = 1'b0;
    logic  rx_stop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Length of every clock-inhibit phase driven by the host.
    initial begin : inh_counter
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (clk_oe === 1'b1) begin
                n++;
            end else if (n > 0) begin
                last_inh_len = n;
                inhib_cnt++;
                n = 0;
            end
        end
    end

    task automatic run_frame();
        logic [10:0] bits;
        bits = '0;
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) dev_data_low = (mode == M_ACK);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (i == abort_at) begin
                dev_clk_low = 1'b0;
                aborts++;
                return;
            end
            bits[i-1] = ps2_data;
            if (i == 10) begin
                rx_byte = bits[7:0];
                rx_par  = bits[8];
                rx_stop = bits[9];
            end
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    // Keyboard: after the host releases clock, clock in a frame.
    initial begin : device
        forever begin
            @(negedge clk);
            if (clk_oe === 1'b1) begin
                while (clk_oe === 1'b1) @(negedge clk);
                req_ok  = data_oe;
                rel_cyc = cyc;
                if (mode != M_SILENT && data_oe) run_frame();
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (ready === 1'b1 && busy === 1'b1) excl_bad++;
            if (done === 1'b1 || err === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: done=%0b err=%0b want none", done, err);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_done", done, e.is_done);
                    chk("pulse_err", err, !e.is_done);
                    if (e.chk_byte) begin
                        chk("rx_byte", rx_byte, e.b);
                        chk("rx_parity", rx_par, ($countones(e.b) % 2) == 0);
                    end
                    if (e.is_done) chk("rx_stop", rx_stop, 1);
                    chk("inhibit_phases", inhib_cnt - e.base, e.phases);
                    chk("inhibit_len", last_inh_len, INH);
                    chk("req_data_low", req_ok, 1);
                    if (!e.is_done) begin
                        chk("err_clk_oe", clk_oe, 0);
                        chk("err_data_oe", data_oe, 0);
                    end
                    if (e.silent) chk("start_timeout", cyc - rel_cyc, STO);
                    @(negedge clk);
                    chk("post_ready", ready, 1);
                    chk("post_busy", busy, 0);
                    chk("post_no_pulse", done | err, 0);
                end
                pulses++;
            end
        end
    end

    function automatic int phases_for(input mode_e m);
`ifdef PS2_TX_RETRY_EN
        return (m == M_ACK) ? 1 : 3;
`else
        return 1;
`endif
    endfunction

    task automatic send(input logic [7:0] b, input mode_e m, input bit push, input bit poke);
        int t;
        exp_t e;
        t = 0;
        while (ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_send", ready, 1);
        mode       = m;
        e.is_done  = (m == M_ACK);
        e.chk_byte = (m != M_SILENT);
        e.silent   = (m == M_SILENT);
        e.b        = b;
        e.phases   = phases_for(m);
        e.base     = inhib_cnt;
        if (push) q.push_back(e);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        valid = 1'b0;
        if (poke) begin
            repeat (100) @(negedge clk);
            valid = 1'b1;
            data  = 8'hF4;
            repeat (200) @(negedge clk);
            valid = 1'b0;
        end
    endtask

    task automatic wait_pulse(input int target);
        int t;
        t = 0;
        while (pulses < target && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("completion_in_time", pulses >= target, 1);
    endtask

    initial begin : stim
        int np;
        int ab0;
        int t;
        np = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_data_oe", data_oe, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send(8'hED, M_ACK, 1, 0); np++; wait_pulse(np);
        send(8'h00, M_ACK, 1, 0); np++; wait_pulse(np);
        send(8'h01, M_ACK, 1, 0); np++; wait_pulse(np);
        for (int i = 0; i < 3; i++) begin
            send(8'($urandom_range(0, 255)), M_ACK, 1, 0);
            np++;
            wait_pulse(np);
        end

        send(8'hFF, M_SILENT, 1, 0); np++; wait_pulse(np);
        send(8'hED, M_NOACK, 1, 0); np++; wait_pulse(np);

        abort_at = 5;
        ab0 = aborts;
        send(8'hF4, M_ACK, 0, 0);
        t = 0;
        while (aborts == ab0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reached", aborts != ab0, 1);
        chk("xfer_busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_clk_oe", clk_oe, 0);
        chk("midrst_data_oe", data_oe, 0);
        chk("midrst_ready", ready, 1);
        rst = 1'b0;
        abort_at = 0;
        repeat (100) @(negedge clk);
        chk("midrst_no_pulse", pulses, np);

        send(8'hF4, M_ACK, 1, 0); np++; wait_pulse(np);
        send(8'hFF, M_ACK, 1, 1); np++; wait_pulse(np);
        send(8'hF4, M_ACK, 1, 0); np++; wait_pulse(np);

        repeat (50) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("ready_busy_exclusive", excl_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), using the standard inhibit / request-to-send / device-clocked sequence. It sits inside the SOC beside the existing PS/2 receiver on the same i_ps2_clk/i_ps2_data lines. It drives the lines only through open-drain enables, which the top maps to tristate pads. o_busy lets the SOC gate the receiver while a transmission is in progress.

Parameters:
INHIBIT_CYC, 1200, cycles clock is held low before request (120 us at 10 MHz)
START_TO_CYC, 150000, max cycles from clock release to first device falling edge (15 ms)
PKT_TO_CYC, 20000, max cycles from first falling edge to ack edge (2 ms)

Ports:
i_clk  in  1  system clock (10 MHz)
i_rst  in  1  synchronous active-high reset
i_valid  in  1  command request; accepted when o_ready=1
i_data  in  8  command byte, captured on accept
o_ready  in/out→out  1  high only in IDLE
o_busy  out  1  high from accept until DONE/ERR exit
o_done  out  1  one-cycle pulse: byte sent and device acked
o_err  out  1  one-cycle pulse: timeout or no ack
i_ps2_clk  in  1  raw PS/2 clock line (asynchronous)
i_ps2_data  in  1  raw PS/2 data line (asynchronous)
o_ps2_clk_oe  out  1  1 = drive PS/2 clock low, 0 = release
o_ps2_data_oe  out  1  1 = drive PS/2 data low, 0 = release

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Line inputs:
  - Each line passes through a 2-FF synchronizer, then a previous-sample register.
  - fall = prev & ~sync.
  - Line change to fall pulse latency is 3 cycles.
- Outputs are all registered.
- Reset values:
  - o_ps2_clk_oe=0, o_ps2_data_oe=0, o_ready=1, o_busy=0, o_done=0, o_err=0.
  - State = IDLE; all counters = 0.
- Reset mid-operation: both lines are released on the cycle after i_rst is sampled, and the in-flight byte is discarded.
- Accept: i_valid & o_ready.
  - Latch shreg = {1'b1 stop, ~^i_data odd parity, i_data}.
  - Start the timer; go to INHIBIT.
  - i_valid while busy is ignored.
- States:
  - IDLE: lines released.
  - INHIBIT: clk_oe=1. After INHIBIT_CYC cycles set data_oe=1 (start bit) and go to REQ.
  - REQ: clk_oe=0 (released), data_oe=1. Timer restarts.
    - First fall: data_oe = ~shreg[0], shift, bitcnt=1, go to XFER.
    - Timer reaching START_TO_CYC: go to ERR.
  - XFER: on each fall, data_oe = ~shreg[0] and shift.
    - Data bits 0..7 are driven on falls 1..8, parity on fall 9, stop (release) on fall 10.
    - After fall 10, go to ACK.
  - ACK: on fall 11, sample synced data.
    - Data = 0: go to WAIT_IDLE.
    - Data = 1 (no ack): go to ERR.
  - WAIT_IDLE: wait until synced clk=1 and data=1, then go to DONE.
  - DONE: o_done pulse for 1 cycle, then IDLE.
  - ERR: o_err pulse for 1 cycle; both lines released; then IDLE.
- Packet timer: PKT_TO_CYC starts at the first fall. Expiry in XFER, ACK or WAIT_IDLE goes to ERR.
- Timing: data is changed only in the cycle after a detected fall, so it is stable well before the device's rising edge.
- Counter widths: $clog2 of the largest parameter. Counters saturate and never wrap.
- o_ready and o_busy are mutually exclusive in every cycle.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: on a timeout or missing ack, the latched byte is retransmitted from INHIBIT, up to 2 retries. o_err pulses only after the third failure; o_busy stays high throughout. A 2-bit retry counter is cleared on accept.
- Undefined: the first failure goes straight to ERR. No retry counter exists.

Decomposition:
- Package ps2_pkg:
  - State enum: IDLE, INHIBIT, REQ, XFER, ACK, WAIT_IDLE, DONE, ERR.
  - Command constants: PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF.
  - PS2_ACK_BYTE=8'hFA, used by the receiver side.
- Sub-module ps2_line_sync: 2-FF synchronizer plus fall detect. Instantiated twice, once for clk and once for data; reusable by the receiver.

Test Plan:
- Send 0xED with the device model acking:
  - clk_oe high for exactly 1200 cycles, then data_oe=1.
  - Bits on falls 1..8 are 1,0,1,1,0,1,1,1; parity bit on the line = 1 (data_oe=0).
  - Stop released; o_done pulses once; o_busy falls.
- Send 0x00: parity on the line = 1. Send 0x01: parity = 0. Device ack → o_done each time.
- Device never clocks after REQ: o_err pulses 150000 cycles after clock release; both oe = 0; o_ready = 1.
- Device leaves data high on fall 11 (no ack): o_err pulses, no o_done. With PS2_TX_RETRY_EN: exactly 3 INHIBIT phases are seen before o_err.
- Assert i_rst in XFER after fall 5: next cycle both oe = 0, o_ready = 1, no done/err pulse. A new i_valid then transmits normally.
- i_valid with 0xF4 while busy sending 0xFF: only 0xFF appears on the wire. 0xF4 is sent only if presented again after o_ready.
